// File: rtl/fetch_pc_gen.sv
// Fetch-address generator: holds the fetch PC, issues one fetch group per
// accepted valid/ready handshake, applies commit/branch redirects and
// predicted targets, and parks in a fault state on misaligned targets.
module fetch_pc_gen #(
    parameter int                 ADDR_W       = 32,
    parameter int                 FETCH_WIDTH  = 2,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'hbfc00000,
    parameter int                 DELAY_SLOT   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   flush_cause,
    input  logic [ADDR_W-1:0]      epc,
    input  logic                   branch_flag,
    input  logic [ADDR_W-1:0]      branch_target,
    input  logic [ADDR_W-1:0]      ex_inst_addr,
    input  logic                   ibuf_full,
    input  logic                   bp_valid,
    input  logic [ADDR_W-1:0]      bp_target,
    output logic                   fetch_req_valid,
    input  logic                   fetch_req_ready,
    output logic [ADDR_W-1:0]      fetch_pc,
    output logic [FETCH_WIDTH-1:0] fetch_mask,
    output logic                   fetch_adel
);

    localparam int                GB       = FETCH_WIDTH * 4;
    localparam logic [ADDR_W-1:0] GB_BYTES = ADDR_W'(GB);
    localparam logic [ADDR_W-1:0] GB_MASK  = ADDR_W'(GB - 1);
    localparam logic [ADDR_W-1:0] FALL_OFS = ADDR_W'(4 * (1 + DELAY_SLOT));

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] advance_pc;
    logic              handshake;

    // Redirect target selection; exception outranks branch resolution.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        redirect_pc = epc;
        if (flush_cause) begin
            redirect_pc = branch_flag ? branch_target : (ex_inst_addr + FALL_OFS);
        end
    end

    // Next sequential group wraps naturally at the top of the address space.
    assign seq_pc     = (fetch_pc & ~GB_MASK) + GB_BYTES;
    assign advance_pc = bp_valid ? bp_target : seq_pc;

    // A flush kills the request in the same cycle, so it can never be accepted
    // alongside a redirect; reset likewise suppresses it.
    assign fetch_req_valid = (state == ST_RUN) && !ibuf_full && !flush && !reset;
    assign handshake       = fetch_req_valid && fetch_req_ready;
    assign fetch_adel      = (state == ST_FAULT);

    // Per-slot valid mask: slots before the entry offset of the PC are skipped.
    generate
        if (FETCH_WIDTH == 1) begin : g_mask_single
            assign fetch_mask = 1'b1;
        end else begin : g_mask_multi
            localparam int OFS_W = $clog2(FETCH_WIDTH);
            logic [OFS_W-1:0] ofs;
            assign ofs = fetch_pc[OFS_W+1:2];
            // Slot i is valid when it lies at or after the entry slot.
            always_comb begin
                fetch_mask = '0;
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    fetch_mask[i] = (i >= int'(ofs));
                end
            end
        end
    endgenerate

    // PC and state update: reset, then flush, then per-state progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (reset) begin
            fetch_pc <= RESET_VECTOR;
            state    <= ST_BOOT;
        end else if (flush) begin
            fetch_pc <= redirect_pc;
            state    <= (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (handshake) begin
                        fetch_pc <= advance_pc;
                        state    <= (advance_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
                    end
                end
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_BOOT;
            endcase
        end
    end

endmodule
